// File: rtl/fp_addsub_rne.sv
// rtl/fp_addsub_rne.sv - multi-cycle parametrised floating-point adder/subtractor, round-to-nearest-even
module fp_addsub_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] data_a,
  input  logic [EXP_W+MAN_W:0] data_b,
  output logic                 busy,
  output logic                 ready,
  output logic [EXP_W+MAN_W:0] data_o,
  output logic                 flag_inv,
  output logic                 flag_ovf,
  output logic                 flag_unf,
  output logic                 flag_inx
);
  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int SW      = MAN_W + 4;
  localparam int LZW     = $clog2(SW);
  localparam int EW      = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [W-1:0]            a_q, b_q;
  logic                    op_q;
  logic                    sign_q, sub_q, spec_q, spec_inv_q, zero_q;
  logic [EXP_W-1:0]        exp_q;
  logic [SW-1:0]           sig_l_q, sig_s_q, nsig_q;
  logic [W-1:0]            spec_res_q, data_o_q;
  logic [SW:0]             sum_q;
  logic signed [EW-1:0]    nexp_q;
  logic [3:0]              flags_q;

  logic                    sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [EXP_W-1:0]        ea, eb, ediff, exp_d;
  logic [MAN_W-1:0]        fa, fb, frac;
  logic [SW-1:0]           sig_l_d, sig_s_d, small_base, lost_mask, nsig_d;
  logic                    sign_d, sub_d, spec_d, spec_inv_d, zero_d, round_up;
  logic [W-1:0]            spec_res_d, res_d;
  logic [SW:0]             sum_d;
  logic [LZW-1:0]          lz;
  logic signed [EW-1:0]    nexp_d, rexp;
  logic [MAN_W+1:0]        mant;
  logic [3:0]              flags_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE:  if (start) begin state_d = S_ALIGN; accept = 1'b1; end
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  begin
        state_d = start ? S_ALIGN : S_IDLE;
        accept  = start;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q == S_ALIGN) || (state_q == S_ADD) ||
                    (state_q == S_NORM)  || (state_q == S_ROUND);
  assign ready    = (state_q == S_DONE);
  assign data_o   = data_o_q;
  assign flag_inv = flags_q[3];
  assign flag_ovf = flags_q[2];
  assign flag_unf = flags_q[1];
  assign flag_inx = flags_q[0];

  // Operand decode, swap so A holds the larger magnitude, and align B with a sticky tail
  always_comb begin
    sa         = a_q[W-1];
    sb         = b_q[W-1] ^ op_q;
    ea         = a_q[W-2 -: EXP_W];
    eb         = b_q[W-2 -: EXP_W];
    fa         = a_q[MAN_W-1:0];
    fb         = b_q[MAN_W-1:0];
    a_zero     = (ea == '0);
    b_zero     = (eb == '0);
    a_inf      = (ea == '1) && (fa == '0);
    b_inf      = (eb == '1) && (fb == '0);
    a_nan      = (ea == '1) && (fa != '0);
    b_nan      = (eb == '1) && (fb != '0);
    swap       = {eb, fb} > {ea, fa};
    sign_d     = swap ? sb : sa;
    sub_d      = sa ^ sb;
    exp_d      = swap ? eb : ea;
    ediff      = swap ? (eb - ea) : (ea - eb);
    sig_l_d    = swap ? {1'b1, fb, 3'b000} : {1'b1, fa, 3'b000};
    small_base = swap ? {1'b1, fa, 3'b000} : {1'b1, fb, 3'b000};
    lost_mask  = ~({SW{1'b1}} << ediff);
    if (32'(ediff) >= 32'(SW - 1)) begin
      sig_s_d = {{(SW-1){1'b0}}, 1'b1};
    end else begin
      sig_s_d    = small_base >> ediff;
      sig_s_d[0] = sig_s_d[0] | (|(small_base & lost_mask));
    end

    spec_d     = 1'b1;
    spec_inv_d = 1'b0;
    spec_res_d = QNAN;
    if (a_nan || b_nan)                  spec_inv_d = 1'b1;
    else if (a_inf && b_inf && sa != sb) spec_inv_d = 1'b1;
    else if (a_inf)                      spec_res_d = {sa, ea, fa};
    else if (b_inf)                      spec_res_d = {sb, eb, fb};
    else if (a_zero && b_zero)           spec_res_d = {sa & sb, {(W-1){1'b0}}};
    else if (a_zero)                     spec_res_d = {sb, eb, fb};
    else if (b_zero)                     spec_res_d = {sa, ea, fa};
    else                                 spec_d = 1'b0;
  end

  always_comb begin
    sum_d = sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                  : ({1'b0, sig_l_q} + {1'b0, sig_s_q});
  end

  // Highest set bit wins, so the ascending scan leaves the leading-zero count
  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++) begin
      if (sum_q[i]) lz = LZW'(SW - 1 - i);
    end
    zero_d = (sum_q == '0);
    if (sum_q[SW]) begin
      nsig_d = {sum_q[SW:2], sum_q[1] | sum_q[0]};
      nexp_d = EW'(exp_q) + EW'(1);
    end else begin
      nsig_d = sum_q[SW-1:0] << lz;
      nexp_d = EW'(exp_q) - EW'(lz);
    end
  end

  always_comb begin
    round_up = nsig_q[2] & (nsig_q[1] | nsig_q[0] | nsig_q[3]);
    mant     = {1'b0, nsig_q[SW-1:3]} + (MAN_W+2)'(round_up);
    rexp     = nexp_q;
    frac     = mant[MAN_W-1:0];
    if (mant[MAN_W+1]) begin
      rexp = nexp_q + EW'(1);
      frac = mant[MAN_W:1];
    end
    res_d   = {sign_q, rexp[EXP_W-1:0], frac};
    flags_d = {3'b000, |nsig_q[2:0]};
    if (spec_q) begin
      res_d   = spec_res_q;
      flags_d = {spec_inv_q, 3'b000};
    end else if (zero_q) begin
      res_d   = '0;
      flags_d = '0;
    end else if (rexp >= EW'(EXP_MAX)) begin
      res_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (rexp < EW'(1)) begin
      res_d   = {sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      exp_q      <= '0;
      sig_l_q    <= '0;
      sig_s_q    <= '0;
      spec_q     <= 1'b0;
      spec_inv_q <= 1'b0;
      spec_res_q <= '0;
      sum_q      <= '0;
      nsig_q     <= '0;
      nexp_q     <= '0;
      zero_q     <= 1'b0;
      data_o_q   <= '0;
      flags_q    <= '0;
    end else begin
      if (accept) begin
        a_q  <= data_a;
        b_q  <= data_b;
        op_q <= op;
      end
      if (state_q == S_ALIGN) begin
        sign_q     <= sign_d;
        sub_q      <= sub_d;
        exp_q      <= exp_d;
        sig_l_q    <= sig_l_d;
        sig_s_q    <= sig_s_d;
        spec_q     <= spec_d;
        spec_inv_q <= spec_inv_d;
        spec_res_q <= spec_res_d;
      end
      if (state_q == S_ADD) sum_q <= sum_d;
      if (state_q == S_NORM) begin
        nsig_q <= nsig_d;
        nexp_q <= nexp_d;
        zero_q <= zero_d;
      end
      if (state_q == S_ROUND) begin
        data_o_q <= res_d;
        flags_q  <= flags_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_rne.sv
// tb/tb_fp_addsub_rne.sv - self-checking bench for fp_addsub_rne against an exact-arithmetic model
module tb_fp_addsub_rne;
  localparam int BW = 320;

  logic        clock, reset, start, op;
  logic [31:0] data_a, data_b, data_o;
  logic        busy, ready, flag_inv, flag_ovf, flag_unf, flag_inx;

  int n_cmp = 0;
  int n_err = 0;

  fp_addsub_rne #(.EXP_W(8), .MAN_W(23)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .data_a(data_a), .data_b(data_b), .busy(busy), .ready(ready),
    .data_o(data_o), .flag_inv(flag_inv), .flag_ovf(flag_ovf),
    .flag_unf(flag_unf), .flag_inx(flag_inx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact sum as wide integers (unit 2^-149), then rounded to nearest-even at 24 bits
  function automatic logic [35:0] ref_fp(input logic [31:0] a, input logic [31:0] b, input logic o);
    logic sa, sb, sr;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic [BW-1:0] ma, mb, mag, q, rem, half;
    logic [31:0] qnan;
    int p, e;
    qnan = 32'h7FC00000;
    sa = a[31]; sb = b[31] ^ o;
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return {4'b1000, qnan};
    if (ea == 8'hFF && eb == 8'hFF && sa != sb) return {4'b1000, qnan};
    if (ea == 8'hFF) return {4'b0000, sa, 8'hFF, 23'h0};
    if (eb == 8'hFF) return {4'b0000, sb, 8'hFF, 23'h0};
    if (ea == 0 && eb == 0) return {4'b0000, sa & sb, 31'h0};
    if (ea == 0) return {4'b0000, sb, eb, fb};
    if (eb == 0) return {4'b0000, a};
    ma = BW'({1'b1, fa}) << (ea - 1);
    mb = BW'({1'b1, fb}) << (eb - 1);
    if (sa == sb)      begin mag = ma + mb; sr = sa; end
    else if (ma >= mb) begin mag = ma - mb; sr = sa; end
    else               begin mag = mb - ma; sr = sb; end
    if (mag == 0) return 36'h0;
    p = 0;
    for (int i = 0; i < BW; i++) if (mag[i]) p = i;
    rem = '0;
    if (p > 23) begin
      q    = mag >> (p - 23);
      rem  = mag - (q << (p - 23));
      half = BW'(1) << (p - 24);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = mag << (23 - p);
    end
    e = p - 22;
    if (q[24]) begin q = q >> 1; e++; end
    if (e >= 255) return {4'b0101, sr, 8'hFF, 23'h0};
    if (e < 1)    return {4'b0011, sr, 31'h0};
    return {3'b000, rem != 0, sr, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp(input int near_e);
    int k, e;
    logic s;
    logic [22:0] f;
    k = int'($urandom_range(0, 15));
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 5))
      0: f = '0;
      1: f = '1;
      2: f = 23'($urandom_range(0, 7));
      default: ;
    endcase
    if (k == 0)      e = 0;
    else if (k == 1) e = 255;
    else if (k == 2) e = 254;
    else if (k == 3) e = 1;
    else if (k < 8)  e = int'($urandom_range(1, 254));
    else begin
      e = near_e + int'($urandom_range(0, 60)) - 30;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
    end
    return {s, e[7:0], f};
  endfunction

  task automatic exec_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic o,
                         input logic [31:0] er, input logic [3:0] ef);
    int lat, bcnt;
    @(negedge clock);
    start = 1'b1; op = o; data_a = a; data_b = b;
    @(posedge clock); #1;
    start = 1'b0; data_a = $urandom; data_b = $urandom; op = ~o;
    lat = 0; bcnt = 0;
    while (!ready && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clock); #1;
      lat++;
    end
    check($sformatf("%s_lat", tag), 64'(lat), 64'(4));
    check($sformatf("%s_busy", tag), 64'(bcnt), 64'(4));
    check($sformatf("%s_res", tag), 64'(data_o), 64'(er));
    check($sformatf("%s_flg", tag), 64'({flag_inv, flag_ovf, flag_unf, flag_inx}), 64'(ef));
    @(posedge clock); #1;
    check($sformatf("%s_rdy_drop", tag), 64'(ready), 64'(0));
    check($sformatf("%s_hold", tag), 64'(data_o), 64'(er));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, er;
    logic [3:0]  ef;
    logic        o;
    int nready, first;

    reset = 1'b0; start = 1'b0; op = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_data", 64'(data_o), 64'(0));
    check("rst_flags", 64'({flag_inv, flag_ovf, flag_unf, flag_inx}), 64'(0));
    @(negedge clock) reset = 1'b1;

    exec_op("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    exec_op("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    exec_op("above_half",32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
    exec_op("sub_equal", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    exec_op("sub_lzc23", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000);
    exec_op("ovf_max",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    exec_op("ovf_carry", 32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101);
    exec_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    exec_op("nan_in",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    exec_op("inf_fin",   32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
    exec_op("nz_pz",     32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
    exec_op("nz_nz",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    exec_op("nz_m_pz",   32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000);
    exec_op("x_m_0",     32'h3F800000, 32'h00000000, 1'b1, 32'h3F800000, 4'b0000);
    exec_op("0_m_x",     32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000);
    exec_op("subn_a",    32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
    exec_op("unf_flush", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    exec_op("neg_mix",   32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000);

    for (int i = 0; i < 300; i++) begin
      a = rand_fp(($urandom_range(0, 1) == 1) ? 127 : int'($urandom_range(1, 254)));
      b = rand_fp((a[30:23] == 8'h00 || a[30:23] == 8'hFF) ? 127 : int'(a[30:23]));
      o = 1'($urandom_range(0, 1));
      {ef, er} = ref_fp(a, b, o);
      exec_op($sformatf("rnd%0d", i), a, b, o, er, ef);
    end

    // start re-pulsed while busy must be ignored
    @(negedge clock);
    start = 1'b1; op = 1'b0; data_a = 32'h3F800000; data_b = 32'h40000000;
    @(posedge clock); #1;
    start = 1'b0;
    nready = 0; first = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      start = (i == 2);
      if (i == 2) begin data_a = 32'h41200000; data_b = 32'h41200000; end
      @(posedge clock); #1;
      start = 1'b0;
      if (ready) begin nready++; if (first < 0) first = i; end
    end
    check("busy_start_nready", 64'(nready), 64'(1));
    check("busy_start_lat", 64'(first), 64'(4));
    check("busy_start_res", 64'(data_o), 64'h40400000);

    // start held high through DONE: back-to-back with 5-cycle throughput
    @(negedge clock);
    start = 1'b1; op = 1'b0; data_a = 32'h3F800000; data_b = 32'h40000000;
    @(posedge clock); #1;
    op = 1'b1; data_a = 32'h40400000; data_b = 32'h3F800000;
    nready = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (i == 6) start = 1'b0;
      @(posedge clock); #1;
      if (i == 4) begin
        check("b2b_rdy1", 64'(ready), 64'(1));
        check("b2b_res1", 64'(data_o), 64'h40400000);
      end
      if (i == 9) begin
        check("b2b_rdy2", 64'(ready), 64'(1));
        check("b2b_res2", 64'(data_o), 64'h40000000);
      end
      if (ready) nready++;
    end
    check("b2b_nready", 64'(nready), 64'(2));

    // reset mid-operation clears outputs at once and drops the op
    exec_op("pre_rst", 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
    @(negedge clock);
    start = 1'b1; op = 1'b0; data_a = 32'h40000000; data_b = 32'h40000000;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_ready", 64'(ready), 64'(0));
    check("mid_rst_data", 64'(data_o), 64'(0));
    check("mid_rst_flags", 64'({flag_inv, flag_ovf, flag_unf, flag_inx}), 64'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    nready = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (ready) nready++;
    end
    check("post_rst_no_ready", 64'(nready), 64'(0));
    exec_op("post_rst", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
